mux_truth_table_scanner: RTL and testbench



---
 rtl/mux_truth_table_scanner.sv | 111 +++++++++++
 tb/tb_mux_truth_table_scanner.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_truth_table_scanner.sv
// Sweeps all 16 {a,b,c,d} vectors into a 4-input function block and compares its output against a golden truth table.
// Optional build macro SCAN_STOP_ON_FAIL_EN: end the scan at the first mismatching vector.
module mux_truth_table_scanner #(
    parameter int SETTLE_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        dut_out,
    output logic [3:0]  drive_abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] captured,
    output logic [4:0]  fail_count,
    output logic [3:0]  first_fail_idx,
    output logic        pass
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT   = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] FIN    = 2'd3;

    // With no settle time each vector goes straight to its sample cycle.
    localparam logic [1:0] VEC_ENTRY   = (SETTLE_CYC == 0) ? SAMPLE : WAIT;
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    logic [1:0]  state;
    logic [3:0]  idx;
    logic [3:0]  settle_cnt;
    logic [15:0] expected_latched;
    logic        mismatch;
    logic        last_vector;

    assign drive_abcd = idx;
    assign mismatch   = (dut_out != expected_latched[idx]);

`ifdef SCAN_STOP_ON_FAIL_EN
    assign last_vector = (idx == 4'd15) || mismatch;
`else
    assign last_vector = (idx == 4'd15);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= 4'd0;
            settle_cnt       <= 4'd0;
            expected_latched <= 16'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            captured         <= 16'd0;
            fail_count       <= 5'd0;
            first_fail_idx   <= 4'd0;
            pass             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        expected_latched <= expected;
                        idx              <= 4'd0;
                        settle_cnt       <= 4'd0;
                        captured         <= 16'd0;
                        fail_count       <= 5'd0;
                        first_fail_idx   <= 4'd0;
                        pass             <= 1'b0;
                        busy             <= 1'b1;
                        state            <= VEC_ENTRY;
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    captured[idx] <= dut_out;
                    if (mismatch) begin
                        fail_count <= fail_count + 5'd1;
                        if (fail_count == 5'd0) begin
                            first_fail_idx <= idx;
                        end
                    end
                    // idx stays on the final vector so drive_abcd holds it afterwards.
                    if (last_vector) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= VEC_ENTRY;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    pass  <= (fail_count == 5'd0);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_truth_table_scanner.sv
// Bench for mux_truth_table_scanner: a cycle-time model of the scan checked every cycle, plus literal end-of-scan expectations.
// Two instances: SETTLE_CYC=1 (instance 0) and SETTLE_CYC=0 (instance 1).
module tb_mux_truth_table_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [2];
    logic [15:0] expected [2];
    logic        dut_out [2];
    logic [3:0]  drive_abcd [2];
    logic        busy [2];
    logic        done [2];
    logic [15:0] captured [2];
    logic [4:0]  fail_count [2];
    logic [3:0]  first_fail_idx [2];
    logic        pass [2];
    logic [15:0] dut_tt [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // The function blocks under test are modelled as truth-table lookups.
    assign dut_out[0] = dut_tt[0][drive_abcd[0]];
    assign dut_out[1] = dut_tt[1][drive_abcd[1]];

    mux_truth_table_scanner #(.SETTLE_CYC(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .expected(expected[0]),
        .dut_out(dut_out[0]), .drive_abcd(drive_abcd[0]), .busy(busy[0]),
        .done(done[0]), .captured(captured[0]), .fail_count(fail_count[0]),
        .first_fail_idx(first_fail_idx[0]), .pass(pass[0])
    );

    mux_truth_table_scanner #(.SETTLE_CYC(0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .expected(expected[1]),
        .dut_out(dut_out[1]), .drive_abcd(drive_abcd[1]), .busy(busy[1]),
        .done(done[1]), .captured(captured[1]), .fail_count(fail_count[1]),
        .first_fail_idx(first_fail_idx[1]), .pass(pass[1])
    );

    // Model state: t_m is the cycle number since the accepting edge (1 = first busy cycle), -1 after reset.
    int          t_m [2] = '{-1, -1};
    logic [15:0] exp_m [2] = '{16'd0, 16'd0};
    logic [15:0] tt_m [2] = '{16'd0, 16'd0};
    bit          armed = 1'b0;

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int vec_count(input logic [15:0] tt, input logic [15:0] ex);
`ifdef SCAN_STOP_ON_FAIL_EN
        for (int v = 0; v < 16; v++) begin
            if (tt[v] != ex[v]) return v + 1;
        end
`endif
        return 16;
    endfunction

    function automatic int scan_len(input int i);
        return vec_count(tt_m[i], exp_m[i]) * (settle_of(i) + 1);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                t_m[i] <= -1;
            end else if (start[i] && (t_m[i] < 0 || t_m[i] >= scan_len(i) + 2)) begin
                t_m[i]   <= 1;
                exp_m[i] <= expected[i];
                tt_m[i]  <= dut_tt[i];
            end else if (t_m[i] > 0) begin
                t_m[i] <= t_m[i] + 1;
            end
        end
        if (reset) armed <= 1'b1;
    end

    task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s inst%0d actual=%0h required=%0h at %0t", name, inst, act, req, $time);
        end
    endtask

    task automatic compareInstance(input int i);
        int          s, nv, n, t, cnt, drv, fc, ffi;
        logic [15:0] mask, mm;
        logic        e_busy, e_done, e_pass;
        s = settle_of(i);
        nv = vec_count(tt_m[i], exp_m[i]);
        n = nv * (s + 1);
        t = t_m[i];
        if (t < 1) begin
            e_busy = 0; e_done = 0; e_pass = 0; drv = 0; mask = 16'd0;
        end else begin
            e_busy = (t <= n);
            e_done = (t == n + 1);
            cnt = (t <= n) ? (t - 1) / (s + 1) : nv;
            drv = (t <= n) ? (t - 1) / (s + 1) : nv - 1;
            mask = (cnt == 16) ? 16'hFFFF : 16'((32'd1 << cnt) - 32'd1);
            e_pass = 0;
        end
        mm = (tt_m[i] ^ exp_m[i]) & mask;
        fc = $countones(mm);
        ffi = 0;
        for (int v = 15; v >= 0; v--) if (mm[v]) ffi = v;
        if (t >= n + 2) e_pass = (fc == 0);
        checkOutput("busy", i, 32'(busy[i]), 32'(e_busy));
        checkOutput("done", i, 32'(done[i]), 32'(e_done));
        checkOutput("drive_abcd", i, 32'(drive_abcd[i]), 32'(drv));
        checkOutput("captured", i, 32'(captured[i]), 32'(tt_m[i] & mask));
        checkOutput("fail_count", i, 32'(fail_count[i]), 32'(fc));
        checkOutput("first_fail_idx", i, 32'(first_fail_idx[i]), 32'(ffi));
        checkOutput("pass", i, 32'(pass[i]), 32'(e_pass));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) compareInstance(i);
        end
    end

    // Pulses start for one edge; returns at the negedge of the first busy cycle.
    task automatic applyStimulus(input int inst, input logic [15:0] ex);
        @(negedge clk);
        expected[inst] = ex;
        start[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
    endtask

    task automatic waitDone(input int inst, input int budget, output int cyc);
        cyc = 1;
        while (done[inst] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (done[inst] !== 1'b1) begin
            checkOutput("done_timeout", inst, 32'(done[inst]), 32'd1);
        end
    endtask

    task automatic checkResults(input int inst, input logic [15:0] cap, input int fc, input int ffi, input logic ps);
        checkOutput("lit_captured", inst, 32'(captured[inst]), 32'(cap));
        checkOutput("lit_fail_count", inst, 32'(fail_count[inst]), 32'(fc));
        checkOutput("lit_first_fail_idx", inst, 32'(first_fail_idx[inst]), 32'(ffi));
        checkOutput("lit_pass", inst, 32'(pass[inst]), 32'(ps));
    endtask

    initial begin
        int cyc, bcnt, dcnt;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            expected[i] = 16'd0;
        end
        dut_tt[0] = 16'h8DC5;
        dut_tt[1] = 16'hAAAA;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkResults(0, 16'h0000, 0, 0, 1'b0);
        checkOutput("lit_reset_busy", 0, 32'(busy[0]), 32'd0);

        // Matching golden table
        applyStimulus(0, 16'h8DC5);
        waitDone(0, 200, cyc);
        checkOutput("lit_done_cycle", 0, 32'(cyc), 32'd33);
        @(negedge clk);
        checkResults(0, 16'h8DC5, 0, 0, 1'b1);

        // Single mismatch at vector 0
        applyStimulus(0, 16'h8DC4);
        waitDone(0, 200, cyc);
        @(negedge clk);
`ifdef SCAN_STOP_ON_FAIL_EN
        checkResults(0, 16'h0001, 1, 0, 1'b0);
`else
        checkResults(0, 16'h8DC5, 1, 0, 1'b0);
`endif

        // Output stuck at 0 against all-ones
        dut_tt[0] = 16'h0000;
        applyStimulus(0, 16'hFFFF);
        waitDone(0, 200, cyc);
        @(negedge clk);
`ifdef SCAN_STOP_ON_FAIL_EN
        checkResults(0, 16'h0000, 1, 0, 1'b0);
`else
        checkResults(0, 16'h0000, 16, 0, 1'b0);
`endif

        // Zero settle time; a start during busy must be ignored
        applyStimulus(1, 16'hAAAA);
        bcnt = 0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            bcnt += int'(busy[1]);
            dcnt += int'(done[1]);
            start[1] = (c == 4);
            if (c == 4) expected[1] = 16'h0000;
            @(negedge clk);
        end
        start[1] = 1'b0;
        checkOutput("lit_busy_cycles", 1, 32'(bcnt), 32'd16);
        checkOutput("lit_done_pulses", 1, 32'(dcnt), 32'd1);
        checkResults(1, 16'hAAAA, 0, 0, 1'b1);

        // Reset during vector 7 discards the scan
        dut_tt[0] = 16'h8DC5;
        applyStimulus(0, 16'h8DC5);
        repeat (14) @(negedge clk);
        checkOutput("lit_drive_v7", 0, 32'(drive_abcd[0]), 32'd7);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("lit_abort_busy", 0, 32'(busy[0]), 32'd0);
        checkResults(0, 16'h0000, 0, 0, 1'b0);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            dcnt += int'(done[0]);
            @(negedge clk);
        end
        checkOutput("lit_abort_no_done", 0, 32'(dcnt), 32'd0);

        // Fresh scan after reset, mismatch at vector 2
        applyStimulus(0, 16'h8DC1);
        waitDone(0, 200, cyc);
`ifdef SCAN_STOP_ON_FAIL_EN
        checkOutput("lit_done_cycle_stop", 0, 32'(cyc), 32'd7);
        @(negedge clk);
        checkResults(0, 16'h0005, 1, 2, 1'b0);
`else
        checkOutput("lit_done_cycle_full", 0, 32'(cyc), 32'd33);
        @(negedge clk);
        checkResults(0, 16'h8DC5, 1, 2, 1'b0);
`endif
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
